// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver:
// FSM encoding and active-low segment patterns {g,f,e,d,c,b,a}.
package ssd_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Entry n is the pattern for hex digit n
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        return SEG_TABLE[v];
    endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd_dd.sv
// Sequential double-dabble binary-to-BCD engine, one bit per cycle.
// Bits carried out of the top nibble set a sticky overflow flag.
module bin2bcd_dd
    import ssd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int IN_WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [IN_WIDTH-1:0]      din,
    output logic [DIGITS-1:0][3:0]   bcd,
    output logic                     ovf,
    output logic                     done
);

    localparam int CW = $clog2(IN_WIDTH + 1);

    logic [IN_WIDTH-1:0]    bin_q, bin_d;
    logic [DIGITS-1:0][3:0] bcd_q, bcd_d, adj;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   active_q, active_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i] >= 4'd5) adj[i] = bcd_q[i] + 4'd3;
        end
        done     = active_q && (cnt_q == CW'(IN_WIDTH - 1));
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        active_d = active_q;
        if (start) begin
            bin_d    = din;
            bcd_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            active_d = 1'b1;
        end else if (active_q) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            ovf_d          = ovf_q | adj[DIGITS-1][3];
            cnt_d          = cnt_q + 1'b1;
            if (done) active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            active_q <= active_d;
        end
    end

    assign bcd = bcd_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// Multi-digit seven-segment scan driver with double-dabble conversion.
// Optional macro SSD_LZ_BLANK_EN blanks leading zero digits.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int IN_WIDTH    = 13,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] num,
    input  logic                load,
    output logic                busy,
    output logic                ovf,
    output logic [DIGITS-1:0]   anode,
    output logic [6:0]          seg
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);

    logic [1:0]             state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   ovf_q, ovf_d;
    logic [DIGITS-1:0][3:0] disp_q, disp_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic                   lit_q, lit_d;
    logic [DIGITS-1:0]      anode_q, anode_d;
    logic [6:0]             seg_q, seg_d;

    logic                   start;
    logic                   eng_done;
    logic                   eng_ovf;
    logic [DIGITS-1:0][3:0] eng_bcd;
    logic                   wrap;
    logic                   lz;

    assign start = (state_q == ST_IDLE) && load;

    bin2bcd_dd #(
        .DIGITS   (DIGITS),
        .IN_WIDTH (IN_WIDTH)
    ) u_dd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (num),
        .bcd   (eng_bcd),
        .ovf   (eng_ovf),
        .done  (eng_done)
    );

    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE:    if (load) state_d = ST_CONVERT;
            ST_CONVERT: if (eng_done) state_d = ST_COMMIT;
            ST_COMMIT: begin
                disp_d  = eng_bcd;
                ovf_d   = eng_ovf;
                state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Digit 0 only lights after the first prescaler wrap
    always_comb begin
        wrap  = (pre_q == PW'(REFRESH_DIV - 1));
        pre_d = wrap ? '0 : pre_q + 1'b1;
        lit_d = lit_q | wrap;
        idx_d = idx_q;
        if (wrap && lit_q) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        anode_d = '1;
        if (lit_d) anode_d[idx_d] = 1'b0;
    end

    always_comb begin
`ifdef SSD_LZ_BLANK_EN
        lz = (idx_d != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) >= idx_d && disp_d[i] != 4'd0) lz = 1'b0;
        end
`else
        lz = 1'b0;
`endif
        seg_d = SEG_BLANK;
        if (lit_d) begin
            if (ovf_d)   seg_d = SEG_DASH;
            else if (lz) seg_d = SEG_BLANK;
            else         seg_d = seg_of(disp_d[idx_d]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            idx_q   <= '0;
            pre_q   <= '0;
            lit_q   <= 1'b0;
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            lit_q   <= lit_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign busy  = busy_q;
    assign ovf   = ovf_q;
    assign anode = anode_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver (4 digits, 14-bit input, divide-by-4 refresh).
// Expected segment patterns come from a decimal model of each loaded value.
module tb_ssd_scan_driver;

    localparam int DIGITS      = 4;
    localparam int IN_WIDTH    = 14;
    localparam int REFRESH_DIV = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load = 1'b0;
    logic [IN_WIDTH-1:0] num = '0;
    logic                busy;
    logic                ovf;
    logic [DIGITS-1:0]   anode;
    logic [6:0]          seg;

    ssd_scan_driver #(
        .DIGITS      (DIGITS),
        .IN_WIDTH    (IN_WIDTH),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .num   (num),
        .load  (load),
        .busy  (busy),
        .ovf   (ovf),
        .anode (anode),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         digit;
        logic [6:0] seg;
    } exp_t;

    exp_t       sbq[$];
    logic [6:0] obs[DIGITS];
    bit         seen[DIGITS];

    logic [6:0] ref_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int pow10[DIGITS] = '{1, 10, 100, 1000};

    function automatic logic [6:0] model_seg(int n, int d);
        if (n > 9999) return 7'h3F;
`ifdef SSD_LZ_BLANK_EN
        if (d > 0 && n < pow10[d]) return 7'h7F;
`endif
        return ref_tab[(n / pow10[d]) % 10];
    endfunction

    task automatic push_expected(input int n);
        exp_t e;
        for (int d = 0; d < DIGITS; d++) begin
            e.digit = d;
            e.seg   = model_seg(n, d);
            sbq.push_back(e);
        end
    endtask

    // Watch the scan and keep the last pattern seen on each digit
    task automatic collect();
        logic [DIGITS-1:0] oh;
        for (int d = 0; d < DIGITS; d++) begin
            seen[d] = 1'b0;
            obs[d]  = 'x;
        end
        repeat (2 * DIGITS * REFRESH_DIV + 4) begin
            @(negedge clk);
            for (int d = 0; d < DIGITS; d++) begin
                oh = DIGITS'(1) << d;
                if (anode == ~oh) begin
                    obs[d]  = seg;
                    seen[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic do_load(input int n, output int busy_cycles);
        @(negedge clk);
        num  = n[IN_WIDTH-1:0];
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (anode !== 4'b1111 || seg !== 7'h7F) begin
            errors++;
            $display("FAIL reset_out: anode=%b seg=%h expected 1111/7f", anode, seg);
        end
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b ovf=%b expected 0/0", busy, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= REFRESH_DIV; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (e < REFRESH_DIV && anode !== 4'b1111) begin
                errors++;
                $display("FAIL reset_dark edge%0d: anode=%b expected 1111", e, anode);
            end else if (e == REFRESH_DIV && (anode !== 4'b1110 || seg !== 7'h40)) begin
                errors++;
                $display("FAIL first_wrap: anode=%b seg=%h expected 1110/40", anode, seg);
            end
        end
    endtask

    task automatic test_convert();
        int   bc;
        exp_t e;
        do_load(1234, bc);
        checks++;
        if (bc !== 15) begin
            errors++;
            $display("FAIL busy_len: got %0d cycles expected 15", bc);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_1234: got %b expected 0", ovf);
        end
        push_expected(1234);
        collect();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (!seen[e.digit] || obs[e.digit] !== e.seg) begin
                errors++;
                $display("FAIL conv_1234 digit%0d: got %h expected %h", e.digit, obs[e.digit], e.seg);
            end
        end
    endtask

    task automatic test_overflow();
        int   bc;
        exp_t e;
        do_load(12000, bc);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", ovf);
        end
        push_expected(12000);
        collect();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (!seen[e.digit] || obs[e.digit] !== e.seg) begin
                errors++;
                $display("FAIL ovf_dash digit%0d: got %h expected %h", e.digit, obs[e.digit], e.seg);
            end
        end
        do_load(5, bc);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", ovf);
        end
        push_expected(5);
        collect();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (!seen[e.digit] || obs[e.digit] !== e.seg) begin
                errors++;
                $display("FAIL conv_5 digit%0d: got %h expected %h", e.digit, obs[e.digit], e.seg);
            end
        end
    endtask

    task automatic test_lz_blank();
        int   bc;
        exp_t e;
        do_load(7, bc);
        push_expected(7);
        collect();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (!seen[e.digit] || obs[e.digit] !== e.seg) begin
                errors++;
                $display("FAIL conv_7 digit%0d: got %h expected %h", e.digit, obs[e.digit], e.seg);
            end
        end
    endtask

    task automatic test_back_to_back();
        int                fell;
        int                rose;
        int                edge_n;
        int                bc;
        logic [DIGITS-1:0] oh;
        bit                hit[DIGITS];
        exp_t              e;
        @(negedge clk);
        num  = 14'd42;
        load = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b expected 1", busy);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        num    = 14'd99;
        fell   = -1;
        rose   = -1;
        edge_n = 2;
        for (int i = 0; i < 40 && rose < 0; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (!busy && fell < 0) fell = edge_n;
            else if (busy && fell >= 0) rose = edge_n;
        end
        load = 1'b0;
        checks++;
        if (fell !== 15 || rose !== 16) begin
            errors++;
            $display("FAIL b2b_timing: idle at k+%0d reaccept at k+%0d expected k+15/k+16", fell, rose);
        end
        for (int d = 0; d < DIGITS; d++) hit[d] = 1'b0;
        repeat (14) begin
            @(negedge clk);
            for (int d = 0; d < DIGITS; d++) begin
                oh = DIGITS'(1) << d;
                if (anode == ~oh && !hit[d]) begin
                    hit[d] = 1'b1;
                    checks++;
                    if (seg !== model_seg(42, d)) begin
                        errors++;
                        $display("FAIL b2b_42 digit%0d: got %h expected %h", d, seg, model_seg(42, d));
                    end
                end
            end
        end
        bc = 0;
        while (busy && bc < 40) begin
            @(posedge clk);
            #1;
            bc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_timeout: busy=%b expected 0", busy);
        end
        push_expected(99);
        collect();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (!seen[e.digit] || obs[e.digit] !== e.seg) begin
                errors++;
                $display("FAIL conv_99 digit%0d: got %h expected %h", e.digit, obs[e.digit], e.seg);
            end
        end
    endtask

    task automatic test_reset_abort();
        int   bc;
        exp_t e;
        @(negedge clk);
        num  = 14'd9999;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || anode !== 4'b1111 || seg !== 7'h7F) begin
            errors++;
            $display("FAIL abort_reset: busy=%b anode=%b seg=%h expected 0/1111/7f", busy, anode, seg);
        end
        @(negedge clk);
        rst = 1'b0;
        push_expected(0);
        collect();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (!seen[e.digit] || obs[e.digit] !== e.seg) begin
                errors++;
                $display("FAIL abort_zero digit%0d: got %h expected %h", e.digit, obs[e.digit], e.seg);
            end
        end
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b ovf=%b expected 0/0", busy, ovf);
        end
        do_load(9999, bc);
        checks++;
        if (bc !== 15 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reconv: busy %0d cycles ovf=%b expected 15/0", bc, ovf);
        end
        push_expected(9999);
        collect();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (!seen[e.digit] || obs[e.digit] !== e.seg) begin
                errors++;
                $display("FAIL conv_9999 digit%0d: got %h expected %h", e.digit, obs[e.digit], e.seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_lz_blank();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
